// File: rtl/tick_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tick_serializer                                              |
// | Description : Parallel-to-serial shifter paced by an external bit tick.    |
// |               Optional even parity bit: define TICK_SERIALIZER_PARITY_EN.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tick_serializer #(
  parameter int WIDTH     = 8,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             r,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic             ready,
  output logic             busy,
  output logic             so,
  output logic             done,
  output logic [WIDTH-1:0] q
);

  localparam int              CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef TICK_SERIALIZER_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef TICK_SERIALIZER_PARITY_EN
  logic             parity_q, parity_d;
`endif

  logic [WIDTH-1:0] shifted;
  logic             data_bit;

  // The output end of the register is fixed by bit order; zeros enter the other end.
  if (LSB_FIRST != 0) begin : g_lsb_first
    assign shifted  = {1'b0, shreg_q[WIDTH-1:1]};
    assign data_bit = shreg_q[0];
  end else begin : g_msb_first
    assign shifted  = {shreg_q[WIDTH-2:0], 1'b0};
    assign data_bit = shreg_q[WIDTH-1];
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef TICK_SERIALIZER_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (load) begin
          shreg_d  = d;
          cnt_d    = '0;
`ifdef TICK_SERIALIZER_PARITY_EN
          parity_d = ^d;
`endif
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (tick) begin
          shreg_d = shifted;
          // Counter saturates on the last bit so it never wraps.
          if (cnt_q == CNT_LAST) begin
`ifdef TICK_SERIALIZER_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
`ifdef TICK_SERIALIZER_PARITY_EN
      S_PAR: begin
        if (tick) begin
          state_d = S_DONE;
        end
      end
`endif
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    ready = 1'b0;
    busy  = 1'b0;
    done  = 1'b0;
    so    = 1'b1;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
      end
      S_SHIFT: begin
        busy = 1'b1;
        so   = data_bit;
      end
`ifdef TICK_SERIALIZER_PARITY_EN
      S_PAR: begin
        busy = 1'b1;
        so   = parity_q;
      end
`endif
      S_DONE: begin
        done = 1'b1;
      end
      default: begin
        so = 1'b1;
      end
    endcase
  end

  assign q = shreg_q;

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef TICK_SERIALIZER_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef TICK_SERIALIZER_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  a_ready_busy_excl: assert property (@(posedge clk) disable iff (r) !(ready && busy));
  a_done_single:     assert property (@(posedge clk) disable iff (r) done |=> !done);
  a_cnt_range:       assert property (@(posedge clk) disable iff (r) cnt_q <= CNT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_tick_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_tick_serializer                                           |
// | Description : Self-checking bench for tick_serializer (MSB- and LSB-first  |
// |               instances side by side). Honours TICK_SERIALIZER_PARITY_EN.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_tick_serializer;

  localparam int WIDTH = 8;
`ifdef TICK_SERIALIZER_PARITY_EN
  localparam int PAR_EN = 1;
  localparam logic [31:0] E_A5  = 32'h14A, E_01M = 32'h003, E_01L = 32'h101;
  localparam logic [31:0] E_FF  = 32'h1FE, E_07M = 32'h00F, E_07L = 32'h1C1;
  localparam logic [31:0] E_03M = 32'h006, E_03L = 32'h180, E_3C  = 32'h078;
`else
  localparam int PAR_EN = 0;
  localparam logic [31:0] E_A5  = 32'h0A5, E_01M = 32'h001, E_01L = 32'h080;
  localparam logic [31:0] E_FF  = 32'h0FF, E_07M = 32'h007, E_07L = 32'h0E0;
  localparam logic [31:0] E_03M = 32'h003, E_03L = 32'h0C0, E_3C  = 32'h03C;
`endif
  localparam int NBITS = WIDTH + PAR_EN;

  logic             clk, r, tick, load;
  logic [WIDTH-1:0] d;
  logic             ready_m, busy_m, so_m, done_m;
  logic             ready_l, busy_l, so_l, done_l;
  logic [WIDTH-1:0] q_m, q_l;

  int n_pass  = 0;
  int n_total = 0;

  tick_serializer #(.WIDTH(WIDTH), .LSB_FIRST(0)) dut_msb (
    .clk(clk), .r(r), .tick(tick), .load(load), .d(d),
    .ready(ready_m), .busy(busy_m), .so(so_m), .done(done_m), .q(q_m)
  );

  tick_serializer #(.WIDTH(WIDTH), .LSB_FIRST(1)) dut_lsb (
    .clk(clk), .r(r), .tick(tick), .load(load), .d(d),
    .ready(ready_l), .busy(busy_l), .so(so_l), .done(done_l), .q(q_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transfer-level model: 0 = waiting, 1 = sending bit m_cnt, 2 = done pulse.
  int               m_mode;
  int               m_cnt;
  logic [WIDTH-1:0] m_word;
  logic             m_par;

  always @(posedge clk or posedge r) begin
    if (r) begin
      m_mode <= 0;
      m_cnt  <= 0;
      m_word <= '0;
      m_par  <= 1'b0;
    end else begin
      case (m_mode)
        0: if (load) begin
          m_mode <= 1;
          m_cnt  <= 0;
          m_word <= d;
          m_par  <= (PAR_EN != 0) ? ^d : 1'b0;
        end
        1: if (tick) begin
          if (m_cnt == NBITS - 1) m_mode <= 2;
          m_cnt <= m_cnt + 1;
        end
        default: m_mode <= 0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic compare_model();
    logic [WIDTH-1:0] eq_m, eq_l;
    logic             es_m, es_l;
    eq_m = '0;
    eq_l = '0;
    es_m = 1'b1;
    es_l = 1'b1;
    if (m_mode == 1) begin
      eq_m = m_word << m_cnt;
      eq_l = m_word >> m_cnt;
      if (m_cnt < WIDTH) begin
        es_m = m_word[WIDTH-1-m_cnt];
        es_l = m_word[m_cnt];
      end else begin
        es_m = m_par;
        es_l = m_par;
      end
    end
    chk("cycle_msb", {ready_m, busy_m, done_m, so_m, q_m},
        {m_mode == 0, m_mode == 1, m_mode == 2, es_m, eq_m});
    chk("cycle_lsb", {ready_l, busy_l, done_l, so_l, q_l},
        {m_mode == 0, m_mode == 1, m_mode == 2, es_l, eq_l});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    compare_model();
  endtask

  task automatic start(input string name, input logic [WIDTH-1:0] word, input bit tick_too);
    load = 1'b1;
    d    = word;
    tick = tick_too;
    step();
    chk({name, "_accepted"}, {busy_m, ready_m}, 2'b10);
    load = 1'b0;
    tick = 1'b0;
  endtask

  task automatic run(input string name, input int per, input logic [31:0] exp_m,
                     input logic [31:0] exp_l, input bit hold_next,
                     input logic [WIDTH-1:0] next_word);
    logic [31:0] cap_m, cap_l;
    int nticks, phase;
    bit fin;
    cap_m  = '0;
    cap_l  = '0;
    nticks = 0;
    phase  = 0;
    fin    = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      tick  = (phase == per - 1);
      phase = tick ? 0 : phase + 1;
      if (tick) begin
        cap_m = {cap_m[30:0], so_m};
        cap_l = {cap_l[30:0], so_l};
        nticks++;
      end
      load = 1'($urandom_range(0, 1));
      d    = WIDTH'($urandom);
      step();
      if (done_m) fin = 1'b1;
    end
    chk({name, "_done_seen"}, fin, 1'b1);
    chk({name, "_ticks"}, nticks, NBITS);
    chk({name, "_bits_msb"}, cap_m, exp_m);
    chk({name, "_bits_lsb"}, cap_l, exp_l);
    chk({name, "_q_at_done"}, {q_m, q_l}, '0);
    tick = 1'b0;
    load = hold_next;
    d    = next_word;
    step();
    chk({name, "_ready_after_done"}, {done_m, ready_m, busy_m}, 3'b010);
    if (hold_next) begin
      step();
      chk({name, "_b2b_accept"}, {busy_m, ready_m}, 2'b10);
      load = 1'b0;
    end
  endtask

  initial begin
    int ndone;
    r    = 1'b1;
    tick = 1'b0;
    load = 1'b0;
    d    = '0;
    step();
    step();
    chk("reset_msb", {ready_m, busy_m, done_m, so_m, q_m}, {4'b1001, 8'h00});
    chk("reset_lsb", {ready_l, busy_l, done_l, so_l, q_l}, {4'b1001, 8'h00});
    r = 1'b0;
    step();

    start("a5", 8'hA5, 1'b0);
    run("a5", 10, E_A5, E_A5, 1'b0, '0);

    start("x01", 8'h01, 1'b0);
    run("x01", 3, E_01M, E_01L, 1'b0, '0);

    // Tick coincident with load must not count as a bit period.
    start("ff", 8'hFF, 1'b1);
    run("ff", 2, E_FF, E_FF, 1'b1, 8'h07);
    run("x07", 4, E_07M, E_07L, 1'b0, '0);

    start("x03", 8'h03, 1'b0);
    run("x03", 5, E_03M, E_03L, 1'b0, '0);

    // Abort after three ticks with an asynchronous reset pulse between edges.
    start("abort", 8'h3C, 1'b0);
    for (int c = 0; c < 12; c++) begin
      tick = ((c % 4) == 3);
      step();
    end
    tick = 1'b0;
    #1;
    r = 1'b1;
    #1;
    chk("abort_async_msb", {q_m, so_m, ready_m, busy_m, done_m}, {8'h00, 4'b1100});
    chk("abort_async_lsb", {q_l, so_l, ready_l, busy_l, done_l}, {8'h00, 4'b1100});
    r = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      tick = 1'($urandom_range(0, 1));
      step();
      if (done_m || done_l) ndone++;
    end
    chk("abort_no_done", ndone, 0);
    chk("abort_idle", {ready_m, ready_l}, 2'b11);
    tick = 1'b0;

    start("x3c", 8'h3C, 1'b0);
    run("x3c", 2, E_3C, E_3C, 1'b0, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
